// File: rtl/jk_mod_updown_counter_pkg.sv
// Shared defaults for the modulo-N JK up/down counter.
// Holds the default geometry used by the top and its cell.
package jk_mod_updown_counter_pkg;

   localparam int DEF_WIDTH   = 4;
   localparam int DEF_MODULUS = 10;

   // Set-only drive for one JK cell: J is high only for a 0 -> 1 move.
   function automatic logic jk_set(input logic nxt, input logic q_bar);
      return nxt & q_bar;
   endfunction

   // Clear-only drive for one JK cell: K is high only for a 1 -> 0 move.
   function automatic logic jk_clr(input logic nxt, input logic q);
      return ~nxt & q;
   endfunction

endpackage

// File: rtl/jk_mod_updown_counter_jk_ff_cell.sv
// Single JK flip-flop storage cell with synchronous active-high reset.
// Ports: clk, reset, j, k in; q, q_bar out.
module jk_ff_cell (
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q,
   output logic q_bar
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b00:   q <= q;
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            default: q <= ~q;
         endcase
      end
   end

   assign q_bar = ~q;

endmodule

// File: rtl/jk_mod_updown_counter.sv
// Modulo-N up/down counter built from JK cells, with cascade carry (tc),
// wrap pulse and illegal-load pulse. Ports: clk, reset, en, up_dn, load,
// load_val in; count, tc, wrap, load_err out.
module jk_mod_updown_counter
   import jk_mod_updown_counter_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int MODULUS = DEF_MODULUS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   localparam logic [WIDTH-1:0] TC_UP = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] q_bar;
   logic             load_ok;
   logic             at_top;
   logic             at_bot;

   assign load_ok = (32'(load_val) < MODULUS);
   assign at_top  = (count == TC_UP);
   assign at_bot  = (count == '0);

   // Explicit compare at both ends, so no 2**WIDTH rollover is relied on.
   always_comb begin
      nxt = count;
      if (load) begin
         nxt = load_ok ? load_val : '0;
      end else if (en) begin
         if (up_dn) nxt = at_top ? '0 : count + 1'b1;
         else       nxt = at_bot ? TC_UP : count - 1'b1;
      end
   end

   // Each bit is set, cleared or held; the toggle code never appears.
   always_comb begin
      j = '0;
      k = '0;
      for (int i = 0; i < WIDTH; i++) begin
         j[i] = jk_set(nxt[i], q_bar[i]);
         k[i] = jk_clr(nxt[i], count[i]);
      end
   end

   assign tc = en & ~load &
               ((up_dn & at_top) | (~up_dn & at_bot));

   // tc already excludes load, so a wrap is exactly an enabled terminal edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         wrap     <= tc;
         load_err <= load & ~load_ok;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_ff_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .j     (j[i]),
         .k     (k[i]),
         .q     (count[i]),
         .q_bar (q_bar[i])
      );
   end

   a_no_toggle : assert property (
      @(posedge clk) disable iff (reset) ((j & k) == '0));

   a_in_range : assert property (
      @(posedge clk) disable iff (reset) (32'(count) < MODULUS));

endmodule

// File: tb/tb_jk_mod_updown_counter.sv
// Scoreboard bench for jk_mod_updown_counter, MODULUS 10 and 16 side by side.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_jk_mod_updown_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       up_dn;
   logic       load;
   logic [3:0] load_val;

   logic [3:0] count_a, count_b;
   logic       tc_a, tc_b;
   logic       wrap_a, wrap_b;
   logic       err_a, err_b;

   always #5 clk = ~clk;

   jk_mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_m10 (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val),
      .count    (count_a),
      .tc       (tc_a),
      .wrap     (wrap_a),
      .load_err (err_a)
   );

   jk_mod_updown_counter #(.WIDTH(4), .MODULUS(16)) u_m16 (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val),
      .count    (count_b),
      .tc       (tc_b),
      .wrap     (wrap_b),
      .load_err (err_b)
   );

   typedef struct {
      int cnt;
      bit tc;
      bit wrap;
      bit err;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   int mods[2] = '{10, 16};
   int m_cnt[2];
   bit m_wrap[2];
   bit m_err[2];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
      end
   endtask

   // Reference: counts live in 0..M-1, moves use modular arithmetic.
   task automatic step(input bit r, input bit e, input bit u,
                       input bit l, input int lv);
      reset    = r;
      en       = e;
      up_dn    = u;
      load     = l;
      load_val = 4'(lv);
      for (int d = 0; d < 2; d++) begin
         exp_t x;
         int   c;
         int   m;
         bit   w;
         bit   er;
         c      = m_cnt[d];
         m      = mods[d];
         x.cnt  = c;
         x.tc   = e && !l && ((u && c == m - 1) || (!u && c == 0));
         x.wrap = m_wrap[d];
         x.err  = m_err[d];
         if (d == 0) q_a.push_back(x);
         else        q_b.push_back(x);
         w  = 1'b0;
         er = 1'b0;
         if (r) begin
            c = 0;
         end else if (l) begin
            er = (lv >= m);
            c  = (lv < m) ? lv : 0;
         end else if (e) begin
            w = u ? (c == m - 1) : (c == 0);
            c = u ? (c + 1) % m : (c + m - 1) % m;
         end
         m_cnt[d]  = c;
         m_wrap[d] = w;
         m_err[d]  = er;
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (q_a.size() > 0) begin
         x = q_a.pop_front();
         chk("m10 count", int'(count_a), x.cnt);
         chk("m10 tc", int'(tc_a), int'(x.tc));
         chk("m10 wrap", int'(wrap_a), int'(x.wrap));
         chk("m10 load_err", int'(err_a), int'(x.err));
      end
      if (q_b.size() > 0) begin
         x = q_b.pop_front();
         chk("m16 count", int'(count_b), x.cnt);
         chk("m16 tc", int'(tc_b), int'(x.tc));
         chk("m16 wrap", int'(wrap_b), int'(x.wrap));
         chk("m16 load_err", int'(err_b), int'(x.err));
      end
   end

   initial begin
      reset    = 1'b1;
      en       = 1'b0;
      up_dn    = 1'b0;
      load     = 1'b0;
      load_val = '0;
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         m_cnt[d]  = 0;
         m_wrap[d] = 1'b0;
         m_err[d]  = 1'b0;
      end

      // count up through the wrap
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0);

      // load then count down through zero
      step(0, 0, 0, 1, 3);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // illegal load on the mod-10 counter
      step(0, 0, 0, 1, 12);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // reset beats a terminal increment; load beats en
      step(0, 0, 0, 1, 9);
      step(1, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 5);
      step(0, 1, 1, 1, 7);
      step(0, 0, 0, 0, 0);

      // en 1,0,0,1 with direction flip from 4
      step(0, 0, 0, 1, 4);
      step(0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // natural wrap on the mod-16 counter, both directions
      step(0, 0, 0, 1, 15);
      step(0, 1, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      for (int i = 0; i < 600; i++) begin
         step(($urandom % 40) == 0,
              ($urandom % 4) != 0,
              1'($urandom),
              ($urandom % 8) == 0,
              int'($urandom % 16));
      end
      step(0, 0, 0, 0, 0);

      @(negedge clk);
      #1;
      chk("scoreboard drained", q_a.size() + q_b.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
